// File: rtl/tamagotchi_needs_fsm_if.sv
// Pet-core signal bundle: raw sensor inputs toward the core, and the
// behaviour state, need levels, alarm and tick pulse toward the display/sound drivers.
interface tamagotchi_needs_fsm_if #(
  parameter int LVL_W = 4
) ();

  logic             light_detected;
  logic             sound_detected;
  logic             movement_detected;
  logic [2:0]       tamagotchi_state;
  logic [LVL_W-1:0] hunger_lvl;
  logic [LVL_W-1:0] energy_lvl;
  logic [LVL_W-1:0] happy_lvl;
  logic             need_alarm;
  logic             game_tick;

  // Sensor front-end / driver side.
  modport master (
    output light_detected,
    output sound_detected,
    output movement_detected,
    input  tamagotchi_state,
    input  hunger_lvl,
    input  energy_lvl,
    input  happy_lvl,
    input  need_alarm,
    input  game_tick
  );

  // Pet core side.
  modport slave (
    input  light_detected,
    input  sound_detected,
    input  movement_detected,
    output tamagotchi_state,
    output hunger_lvl,
    output energy_lvl,
    output happy_lvl,
    output need_alarm,
    output game_tick
  );

endinterface

// File: rtl/tamagotchi_needs_fsm.sv
// Pet core: synchronises and debounces three raw sensors, keeps three saturating
// need levels that evolve on a divided game tick, and runs a 5-state behaviour FSM.
module tamagotchi_needs_fsm #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DECAY_TICKS = 10,
  parameter int DEBOUNCE    = 500_000,
  parameter int LVL_W       = 4,
  parameter int HUNGRY_TH   = 4,
  parameter int FEED_AMT    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  tamagotchi_needs_fsm_if.slave  bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DEC_W  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECAY_TICKS - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX   = '1;
  localparam logic [LVL_W-1:0]  HUNGRY_V  = LVL_W'(HUNGRY_TH);
  localparam logic [LVL_W:0]    FEED_V    = (LVL_W+1)'(FEED_AMT);

  localparam int IDX_LIGHT = 0;
  localparam int IDX_SOUND = 1;
  localparam int IDX_MOVE  = 2;

  typedef enum logic [2:0] {
    ST_SLEEPING  = 3'd0,
    ST_AWAKE     = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_HUNGRY    = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_e;

  // Level step in LVL_W+1 bits: add, then decrement without going below zero,
  // then clamp to LVL_MAX so a level can never wrap in either direction.
  function automatic logic [LVL_W-1:0] sat_step(input logic [LVL_W-1:0] lvl,
                                                input logic [LVL_W:0]   add,
                                                input logic             dec);
    logic [LVL_W:0] sum;
    // NOTE: blocking '=' belongs in functions and always_comb; flops below use '<=' only.
    sum = {1'b0, lvl} + add;
    if (dec && (sum != '0)) sum = sum - (LVL_W+1)'(1);
    if (sum > {1'b0, LVL_MAX}) return LVL_MAX;
    return sum[LVL_W-1:0];
  endfunction

  logic [2:0]            raw;
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic                  move_prev_q, move_prev_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                  game_tick_q, game_tick_d;
  logic [DEC_W-1:0]      decay_cnt_q, decay_cnt_d;
  logic [LVL_W-1:0]      hunger_q, hunger_d;
  logic [LVL_W-1:0]      energy_q, energy_d;
  logic [LVL_W-1:0]      happy_q, happy_d;
  logic                  need_alarm_q, need_alarm_d;
  state_e                state_q, state_d;

  logic decay_evt, feed;
  logic h_dec, e_inc, e_dec, p_inc, p_dec;

  assign raw = {bus.movement_detected, bus.sound_detected, bus.light_detected};

  // Sensor synchroniser and per-sensor debounce filter.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    sync1_d     = raw;
    sync2_d     = sync1_q;
    filt_d      = filt_q;
    db_cnt_d    = '0;
    move_prev_d = filt_q[IDX_MOVE];
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) filt_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Game-tick divider and slow-decay counter.
  always_comb begin
    tick_cnt_d  = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TICK_W'(1);
    game_tick_d = (tick_cnt_q == TICK_LAST);
    decay_cnt_d = decay_cnt_q;
    if (game_tick_q) decay_cnt_d = (decay_cnt_q == DEC_LAST) ? '0 : decay_cnt_q + DEC_W'(1);
  end

  assign decay_evt = game_tick_q && (decay_cnt_q == DEC_LAST);
  assign feed      = filt_q[IDX_MOVE] && !move_prev_q &&
                     ((state_q == ST_AWAKE) || (state_q == ST_HUNGRY));

  // Need-level evolution, selected by the state held during the tick cycle.
  always_comb begin
    h_dec = 1'b0;
    e_inc = 1'b0;
    e_dec = 1'b0;
    p_inc = 1'b0;
    p_dec = 1'b0;
    case (state_q)
      ST_SLEEPING: begin
        e_inc = game_tick_q;
        h_dec = decay_evt;
      end
      ST_AWAKE: begin
        h_dec = decay_evt;
        e_dec = decay_evt;
        p_dec = decay_evt;
      end
      ST_PLAYING: begin
        p_inc = game_tick_q;
        e_dec = game_tick_q;
        h_dec = decay_evt;
      end
      ST_HUNGRY: begin
        p_dec = decay_evt;
        h_dec = decay_evt;
      end
      ST_EXHAUSTED: e_inc = game_tick_q;
      default: ;
    endcase
    hunger_d     = sat_step(hunger_q, feed ? FEED_V : '0, h_dec);
    energy_d     = sat_step(energy_q, (LVL_W+1)'(e_inc), e_dec);
    happy_d      = sat_step(happy_q,  (LVL_W+1)'(p_inc), p_dec);
    need_alarm_d = (hunger_q == '0) || (energy_q == '0) || (happy_q == '0);
  end

  // Behaviour FSM next state; first matching condition in each state wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SLEEPING:
        if ((energy_q == LVL_MAX) || (filt_q != '0)) state_d = ST_AWAKE;
      ST_AWAKE:
        if (energy_q == '0)                state_d = ST_EXHAUSTED;
        else if (!filt_q[IDX_LIGHT])       state_d = ST_SLEEPING;
        else if (hunger_q <= HUNGRY_V)     state_d = ST_HUNGRY;
        else if (filt_q[IDX_SOUND])        state_d = ST_PLAYING;
      ST_PLAYING:
        if (energy_q == '0)                state_d = ST_EXHAUSTED;
        else if (hunger_q <= HUNGRY_V)     state_d = ST_HUNGRY;
        else if (!filt_q[IDX_SOUND])       state_d = ST_AWAKE;
      ST_HUNGRY:
        if (energy_q == '0)                state_d = ST_EXHAUSTED;
        else if (hunger_q > HUNGRY_V)      state_d = ST_AWAKE;
      ST_EXHAUSTED:
        if (energy_q == LVL_MAX)           state_d = ST_SLEEPING;
      default:                             state_d = ST_SLEEPING;
    endcase
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      filt_q       <= '0;
      db_cnt_q     <= '0;
      move_prev_q  <= 1'b0;
      tick_cnt_q   <= '0;
      game_tick_q  <= 1'b0;
      decay_cnt_q  <= '0;
      hunger_q     <= LVL_MAX;
      energy_q     <= LVL_MAX;
      happy_q      <= LVL_MAX;
      need_alarm_q <= 1'b0;
      state_q      <= ST_SLEEPING;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      filt_q       <= filt_d;
      db_cnt_q     <= db_cnt_d;
      move_prev_q  <= move_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      game_tick_q  <= game_tick_d;
      decay_cnt_q  <= decay_cnt_d;
      hunger_q     <= hunger_d;
      energy_q     <= energy_d;
      happy_q      <= happy_d;
      need_alarm_q <= need_alarm_d;
      state_q      <= state_d;
    end
  end

  assign bus.tamagotchi_state = state_q;
  assign bus.hunger_lvl       = hunger_q;
  assign bus.energy_lvl       = energy_q;
  assign bus.happy_lvl        = happy_q;
  assign bus.need_alarm       = need_alarm_q;
  assign bus.game_tick        = game_tick_q;

endmodule

// File: tb/tb_tamagotchi_needs_fsm.sv
// Scoreboard bench for tamagotchi_needs_fsm with small parameters
// (TICK_DIV=4, DECAY_TICKS=2, DEBOUNCE=3, LVL_W=4, HUNGRY_TH=4, FEED_AMT=6).
// cyc counts non-reset clock edges since the last reset; expectations are
// keyed by cyc and checked on the falling edge of that cycle.
module tb_tamagotchi_needs_fsm;

  localparam int LVL_W = 4;

  typedef enum int {SIG_STATE, SIG_HUNGER, SIG_ENERGY, SIG_HAPPY, SIG_ALARM, SIG_TICK} sig_e;
  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mon_act;
  exp_t sb_q[$];

  tamagotchi_needs_fsm_if #(.LVL_W(LVL_W)) bus ();

  tamagotchi_needs_fsm #(
    .TICK_DIV(4), .DECAY_TICKS(2), .DEBOUNCE(3),
    .LVL_W(LVL_W), .HUNGRY_TH(4), .FEED_AMT(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic void expect_at(input int c, input sig_e s, input int v, input string name);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = name;
    sb_q.push_back(e);
  endfunction

  function automatic int observe(input sig_e s);
    case (s)
      SIG_STATE:  return int'(bus.tamagotchi_state);
      SIG_HUNGER: return int'(bus.hunger_lvl);
      SIG_ENERGY: return int'(bus.energy_lvl);
      SIG_HAPPY:  return int'(bus.happy_lvl);
      SIG_ALARM:  return int'(bus.need_alarm);
      SIG_TICK:   return int'(bus.game_tick);
      default:    return -1;
    endcase
  endfunction

  // Monitor: pops every expectation due in this cycle and compares it.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc <= cyc) begin
          n_tests++;
          if (sb_q[i].cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: due at cyc %0d, not sampled (now cyc %0d)", sb_q[i].name, sb_q[i].cyc, cyc);
          end else begin
            mon_act = observe(sb_q[i].sig);
            if (mon_act != sb_q[i].val) begin
              n_fail++;
              $display("FAIL %s cyc=%0d got=%0d expected=%0d", sb_q[i].name, cyc, mon_act, sb_q[i].val);
            end
          end
          sb_q.delete(i);
        end
      end
    end
  end

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc != c && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != c) begin
      n_tests++; n_fail++;
      $display("FAIL wait_cyc: stuck at cyc %0d, wanted %0d", cyc, c);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb_q.size() != 0) begin
      n_tests += sb_q.size(); n_fail += sb_q.size();
      $display("FAIL drain: %0d expectations never checked", sb_q.size());
      sb_q.delete();
    end
  endtask

  // One-edge reset, then raw sensors take their new values (cyc becomes 0).
  task automatic do_reset(input logic l, input logic s, input logic m);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.light_detected    = l;
    bus.sound_detected    = s;
    bus.movement_detected = m;
  endtask

  task automatic expect_reset_values(input string tag);
    expect_at(0, SIG_STATE,  0,  {tag, "_rst_state"});
    expect_at(0, SIG_HUNGER, 15, {tag, "_rst_hunger"});
    expect_at(0, SIG_ENERGY, 15, {tag, "_rst_energy"});
    expect_at(0, SIG_HAPPY,  15, {tag, "_rst_happy"});
    expect_at(0, SIG_ALARM,  0,  {tag, "_rst_alarm"});
    expect_at(0, SIG_TICK,   0,  {tag, "_rst_tick"});
    expect_at(3, SIG_TICK,   0,  {tag, "_tick_c3"});
    expect_at(4, SIG_TICK,   1,  {tag, "_tick_c4"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.light_detected    = 1'b0;
    bus.sound_detected    = 1'b0;
    bus.movement_detected = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Wake-up with light held; sound glitch rejected; held sound -> PLAYING.
    do_reset(1'b1, 1'b0, 1'b0);
    expect_reset_values("A");
    expect_at(1,  SIG_STATE,  1,  "A_wake_full_energy");
    expect_at(2,  SIG_STATE,  0,  "A_dark_sleep");
    expect_at(3,  SIG_STATE,  1,  "A_wake_again");
    expect_at(4,  SIG_STATE,  0,  "A_sleep_again");
    expect_at(5,  SIG_STATE,  1,  "A_awake_c5");
    expect_at(5,  SIG_TICK,   0,  "A_tick_c5");
    expect_at(5,  SIG_ENERGY, 15, "A_energy_sat");
    expect_at(6,  SIG_STATE,  1,  "A_awake_stable");
    expect_at(8,  SIG_TICK,   1,  "A_tick_c8");
    expect_at(9,  SIG_HUNGER, 14, "A_hunger_decay");
    expect_at(9,  SIG_ENERGY, 14, "A_energy_decay");
    expect_at(9,  SIG_HAPPY,  14, "A_happy_decay");
    for (int c = 14; c <= 17; c++) expect_at(c, SIG_STATE, 1, "A_glitch_ignored");
    expect_at(25, SIG_STATE,  1,  "A_pre_play");
    expect_at(26, SIG_STATE,  2,  "A_playing");
    wait_cyc(10); bus.sound_detected = 1'b1;
    wait_cyc(12); bus.sound_detected = 1'b0;
    wait_cyc(20); bus.sound_detected = 1'b1;
    drain();

    // Hunger decays to threshold -> HUNGRY; feed -> hunger +6 -> AWAKE.
    do_reset(1'b1, 1'b0, 1'b0);
    expect_at(89, SIG_HUNGER, 4,  "B_hunger_c89");
    expect_at(89, SIG_ENERGY, 4,  "B_energy_c89");
    expect_at(89, SIG_HAPPY,  4,  "B_happy_c89");
    expect_at(89, SIG_STATE,  1,  "B_awake_c89");
    expect_at(90, SIG_STATE,  3,  "B_hungry");
    expect_at(95, SIG_HUNGER, 4,  "B_pre_feed");
    expect_at(96, SIG_HUNGER, 10, "B_fed");
    expect_at(96, SIG_STATE,  3,  "B_still_hungry");
    expect_at(97, SIG_STATE,  1,  "B_awake_after_feed");
    expect_at(97, SIG_HUNGER, 9,  "B_hungry_decay_hunger");
    expect_at(97, SIG_HAPPY,  3,  "B_hungry_decay_happy");
    expect_at(97, SIG_ENERGY, 4,  "B_hungry_energy_hold");
    expect_at(97, SIG_ALARM,  0,  "B_alarm_low");
    wait_cyc(90); bus.movement_detected = 1'b1;
    drain();

    // Play until exhausted, then recover to SLEEPING.
    do_reset(1'b1, 1'b1, 1'b0);
    expect_at(5,   SIG_STATE,  1,  "C_awake_c5");
    expect_at(6,   SIG_STATE,  2,  "C_playing");
    expect_at(9,   SIG_HAPPY,  15, "C_happy_sat_c9");
    expect_at(9,   SIG_ENERGY, 14, "C_energy_c9");
    expect_at(9,   SIG_HUNGER, 14, "C_hunger_c9");
    expect_at(33,  SIG_HAPPY,  15, "C_happy_sat_c33");
    expect_at(33,  SIG_ENERGY, 8,  "C_energy_c33");
    expect_at(65,  SIG_ENERGY, 0,  "C_energy_zero");
    expect_at(65,  SIG_HUNGER, 7,  "C_hunger_c65");
    expect_at(65,  SIG_STATE,  2,  "C_still_playing");
    expect_at(65,  SIG_ALARM,  0,  "C_alarm_lag");
    expect_at(66,  SIG_STATE,  4,  "C_exhausted");
    expect_at(66,  SIG_ALARM,  1,  "C_alarm_set");
    expect_at(69,  SIG_ENERGY, 1,  "C_energy_recover");
    expect_at(69,  SIG_ALARM,  1,  "C_alarm_hold");
    expect_at(70,  SIG_ALARM,  0,  "C_alarm_clear");
    expect_at(125, SIG_ENERGY, 15, "C_energy_full");
    expect_at(125, SIG_STATE,  4,  "C_exhausted_c125");
    expect_at(126, SIG_STATE,  0,  "C_sleeping");
    expect_at(126, SIG_HUNGER, 7,  "C_hunger_hold");
    expect_at(126, SIG_HAPPY,  15, "C_happy_hold");
    expect_at(127, SIG_STATE,  1,  "C_rewake");
    drain();

    // Feed in the same cycle as a decay event at hunger 12 -> clamps at 15.
    do_reset(1'b1, 1'b0, 1'b0);
    expect_at(32, SIG_HUNGER, 12, "D_hunger_c32");
    expect_at(32, SIG_TICK,   1,  "D_tick_c32");
    expect_at(33, SIG_HUNGER, 15, "D_feed_clamp");
    expect_at(33, SIG_ENERGY, 11, "D_energy_c33");
    expect_at(33, SIG_HAPPY,  11, "D_happy_c33");
    expect_at(33, SIG_STATE,  1,  "D_awake_c33");
    wait_cyc(27); bus.movement_detected = 1'b1;
    drain();

    // Reset for one edge in the middle of PLAYING.
    do_reset(1'b1, 1'b1, 1'b0);
    expect_at(6,  SIG_STATE,  2,  "E_playing");
    expect_at(25, SIG_ENERGY, 10, "E_energy_c25");
    expect_at(28, SIG_STATE,  2,  "E_playing_c28");
    wait_cyc(29);
    drain();
    do_reset(1'b1, 1'b1, 1'b0);
    expect_reset_values("E");
    expect_at(1, SIG_STATE, 1, "E_rewake");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
